// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN layer sequencer: op-code layout, operation codes,
// sequencer states and the legal-operation test.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        OP_IDLE         = 3'b000,
        OP_CONV         = 3'b001,
        OP_CONV_POOL    = 3'b010,
        OP_FC           = 3'b011,
        OP_CONV_POOL_FC = 3'b110,
        OP_OUT          = 3'b111
    } op_e;

    typedef struct packed {
        logic [4:0] wdim;
        logic [5:0] nfilt;
        logic [2:0] op;
    } op_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } seq_state_e;

    localparam int OP_W = 14;

    // OP_IDLE is deliberately not legal: it must never pulse the controller.
    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_CONV, OP_CONV_POOL, OP_FC, OP_CONV_POOL_FC, OP_OUT: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_prog_mem.sv
// Layer program store: DEPTH x 14-bit register file, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module cnn_seq_prog_mem
    import cnn_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  op_code_t      wr_data,
    input  logic [AW-1:0] rd_addr,
    output op_code_t      rd_data
);

    op_code_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Issues one op code per layer of a host-loaded program and waits for the
// controller's layer-done pulse. Optional per-layer watchdog: SEQ_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | accepts program writes and start
// S_ISSUE | one cycle: op code on op_code_o (0 if the entry is skipped)
// S_WAIT  | waiting for layer_done_i
// S_GAP   | idle spacing before the next issue
// S_DONE  | one cycle: seq_done_o pulse, busy_o drops afterwards
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = $clog2(DEPTH),
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_valid_i,
    output logic            prog_ready_o,
    input  logic [AW-1:0]   prog_addr_i,
    input  logic [OP_W-1:0] prog_data_i,
    input  logic            start_i,
    input  logic [AW:0]     num_layers_i,
    input  logic            layer_done_i,
    output logic [OP_W-1:0] op_code_o,
    output logic            busy_o,
    output logic            seq_done_o,
    output logic            err_o,
    output logic [AW-1:0]   cur_layer_o
);

    if (DEPTH < 2 || GAP_CYC < 0 || GAP_CYC > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("cnn_layer_sequencer: parameter out of range");
    end

    localparam logic [3:0] GAP_LD = 4'(GAP_CYC);
    localparam logic [AW:0] N_MAX = (AW + 1)'(DEPTH);

    seq_state_e  state;
    logic [AW:0] n_lat;
    logic [AW:0] l_idx;
    logic [AW:0] l_nxt;
    logic [3:0]  gap_cnt;
    logic [AW-1:0] rd_addr;
    op_code_t    rd_data;
    logic        prog_we;
    logic        issue_ok;
    logic        start_ok;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] WAIT_LD = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] wait_cnt;
`endif

    // In S_IDLE the read port already points at entry 0 so the first issue
    // can be registered on the same edge that accepts start.
    assign rd_addr  = (state == S_IDLE) ? '0 : l_idx[AW-1:0];
    assign prog_we  = prog_valid_i && prog_ready_o;
    assign issue_ok = is_legal_op(rd_data.op);
    assign start_ok = (num_layers_i != '0) && (num_layers_i <= N_MAX);
    assign l_nxt    = l_idx + 1'b1;

    cnn_seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .we      (prog_we),
        .wr_addr (prog_addr_i),
        .wr_data (op_code_t'(prog_data_i)),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            n_lat        <= '0;
            l_idx        <= '0;
            gap_cnt      <= '0;
            op_code_o    <= '0;
            prog_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            seq_done_o   <= 1'b0;
            err_o        <= 1'b0;
            cur_layer_o  <= '0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            op_code_o  <= '0;
            seq_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    prog_ready_o <= 1'b1;
                    if (start_i) begin
                        if (start_ok) begin
                            n_lat        <= num_layers_i;
                            l_idx        <= '0;
                            cur_layer_o  <= '0;
                            err_o        <= 1'b0;
                            busy_o       <= 1'b1;
                            prog_ready_o <= 1'b0;
                            op_code_o    <= issue_ok ? rd_data : '0;
                            state        <= S_ISSUE;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_ok) begin
`ifdef SEQ_TIMEOUT_EN
                        wait_cnt <= WAIT_LD;
`endif
                        state <= S_WAIT;
                    end else begin
                        err_o       <= 1'b1;
                        l_idx       <= l_nxt;
                        cur_layer_o <= l_nxt[AW-1:0];
                        gap_cnt     <= GAP_LD;
                        state       <= S_GAP;
                    end
                end
                S_WAIT: begin
                    if (layer_done_i) begin
                        l_idx       <= l_nxt;
                        cur_layer_o <= l_nxt[AW-1:0];
                        if (l_nxt == n_lat) begin
                            seq_done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            gap_cnt <= GAP_LD;
                            state   <= S_GAP;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        err_o      <= 1'b1;
                        seq_done_o <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    // A zero gap still spends one cycle here.
                    if (gap_cnt <= 4'd1) begin
                        if (l_idx >= n_lat) begin
                            seq_done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            op_code_o <= issue_ok ? rd_data : '0;
                            state     <= S_ISSUE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    busy_o       <= 1'b0;
                    prog_ready_o <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (layer_done_i && state != S_WAIT) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized self-checking bench for cnn_layer_sequencer; expected issue and
// completion cycles come from a per-layer timeline model.
module tb_cnn_layer_sequencer;

    localparam int DEPTH       = 16;
    localparam int AW          = 4;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            prog_valid_i = 1'b0;
    logic            prog_ready_o;
    logic [AW-1:0]   prog_addr_i = '0;
    logic [13:0]     prog_data_i = '0;
    logic            start_i = 1'b0;
    logic [AW:0]     num_layers_i = '0;
    logic            layer_done_i = 1'b0;
    logic [13:0]     op_code_o;
    logic            busy_o;
    logic            seq_done_o;
    logic            err_o;
    logic [AW-1:0]   cur_layer_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [13:0] model_mem [DEPTH];
    logic [2:0]  legal_ops [5] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

    cnn_layer_sequencer #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_valid_i (prog_valid_i),
        .prog_ready_o (prog_ready_o),
        .prog_addr_i  (prog_addr_i),
        .prog_data_i  (prog_data_i),
        .start_i      (start_i),
        .num_layers_i (num_layers_i),
        .layer_done_i (layer_done_i),
        .op_code_o    (op_code_o),
        .busy_o       (busy_o),
        .seq_done_o   (seq_done_o),
        .err_o        (err_o),
        .cur_layer_o  (cur_layer_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] op);
        return op inside {3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog_write(input int a, input logic [13:0] d);
        check_val("prog_ready", prog_ready_o, 1);
        prog_valid_i = 1'b1;
        prog_addr_i  = AW'(a);
        prog_data_i  = d;
        cyc();
        prog_valid_i = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_op"}, op_code_o, 0);
        check_val({tag, "_busy"}, busy_o, 0);
        check_val({tag, "_seq_done"}, seq_done_o, 0);
        check_val({tag, "_err"}, err_o, 0);
        check_val({tag, "_cur_layer"}, cur_layer_o, 0);
        check_val({tag, "_prog_ready"}, prog_ready_o, 0);
    endtask

    // Runs an n-layer program. Cycle c=1 is the cycle after the start edge.
    // Each legal layer is issued at t, done arrives d cycles later, and the
    // next layer issues after the gap; a skipped layer costs 1+gap cycles.
    task automatic run_prog(input int n, input int fixed_d, input bit spur,
                            input bit restart, input int abort_at);
        int gap;
        int t;
        int d;
        int end_c;
        int spur_c;
        int abort_c;
        int ii;
        int di;
        bit exp_err;
        bit hit;
        logic [13:0] exp_op;
        int iss_c[$];
        int iss_l[$];
        int dn_c[$];
        logic [13:0] iss_v[$];
        gap = (GAP_CYC == 0) ? 1 : GAP_CYC;
        t = 1; end_c = 0; spur_c = -1; abort_c = -1; exp_err = 0; ii = 0; di = 0;
        for (int i = 0; i < n; i++) begin
            d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 6));
            if (ref_legal(model_mem[i][2:0])) begin
                iss_c.push_back(t);
                iss_v.push_back(model_mem[i]);
                iss_l.push_back(i);
                dn_c.push_back(t + d);
                if (i == abort_at) abort_c = t + 1;
                if (i == n - 1) begin
                    end_c = t + d + 1;
                end else begin
                    if (spur && spur_c < 0) spur_c = t + d + 1;
                    t = t + d + gap + 1;
                end
            end else begin
                exp_err = 1;
                if (i == n - 1) end_c = t + gap + 1;
                else            t = t + gap + 1;
            end
        end
        if (spur_c > 0) exp_err = 1;

        start_i      = 1'b1;
        num_layers_i = (AW + 1)'(n);
        for (int c = 1; c <= end_c + 2; c++) begin
            cyc();
            exp_op = '0;
            if (ii < iss_c.size() && iss_c[ii] == c) begin
                exp_op = iss_v[ii];
                check_val("cur_layer", cur_layer_o, iss_l[ii]);
                ii++;
            end
            check_val("op_code", op_code_o, exp_op);
            check_val("seq_done", seq_done_o, (c == end_c));
            check_val("busy", busy_o, (c <= end_c));
            if (c == 1) check_val("err_cleared", err_o, 0);

            start_i      = restart && (c == 2);
            num_layers_i = restart ? (AW + 1)'(1) : (AW + 1)'(n);
            hit = (di < dn_c.size()) && (dn_c[di] == c);
            if (hit) di++;
            layer_done_i = hit || (c == spur_c);

            if (c == abort_c) begin
                rst = 1'b1;
                cyc();
                check_all_zero("abort");
                rst = 1'b0;
                cyc();
                check_val("abort_no_done", seq_done_o, 0);
                check_val("abort_ready", prog_ready_o, 1);
                return;
            end
        end
        start_i = 1'b0;
        layer_done_i = 1'b0;
        check_val("err_end", err_o, exp_err);
        check_val("layers_issued", ii, iss_c.size());
    endtask

    task automatic bad_start(input int n);
        start_i = 1'b1;
        num_layers_i = (AW + 1)'(n);
        cyc();
        start_i = 1'b0;
        check_val("bad_start_err", err_o, 1);
        check_val("bad_start_busy", busy_o, 0);
        cyc();
        check_val("bad_start_busy2", busy_o, 0);
        check_val("bad_start_ready", prog_ready_o, 1);
    endtask

    initial begin
        logic [13:0] v;
        int n;
        bit seen;

        @(negedge clk);
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();
        cyc();
        check_val("ready_after_reset", prog_ready_o, 1);

        // Directed two-layer program with slow done.
        prog_write(0, 14'h0A51);
        prog_write(1, 14'h1C52);
        run_prog(2, 20, 0, 0, -1);

        // Single illegal layer is skipped, never pulsing the controller.
        prog_write(0, 14'h0004);
        run_prog(1, 1, 0, 0, -1);

        // Out-of-range layer counts.
        bad_start(0);
        bad_start(DEPTH + 1);

        // Spurious done in the gap and a second start while busy.
        prog_write(0, 14'h0A51);
        prog_write(1, 14'h1C52);
        prog_write(2, 14'h0003);
        run_prog(3, 0, 1, 1, -1);

        // Reset while waiting on layer 3, then a clean rerun from layer 0.
        for (int i = 0; i < 6; i++) prog_write(i, {5'(i), 6'(i + 1), legal_ops[i % 5]});
        run_prog(6, 0, 0, 0, 3);
        run_prog(6, 0, 0, 0, -1);

        // Random programs with mixed legal and skipped entries.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 14'($urandom);
                if ($urandom_range(0, 3) != 0) v[2:0] = legal_ops[$urandom_range(0, 4)];
                prog_write(i, v);
            end
            n = (k == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            run_prog(n, 0, 0, 0, -1);
        end

        // Controller never reports done.
        prog_write(0, 14'h0A51);
        start_i = 1'b1;
        num_layers_i = (AW + 1)'(1);
        cyc();
        start_i = 1'b0;
        check_val("stall_issue", op_code_o, 14'h0A51);
`ifdef SEQ_TIMEOUT_EN
        seen = 0;
        for (int c = 0; c < TIMEOUT_CYC + 20 && !seen; c++) begin
            cyc();
            if (seq_done_o) seen = 1;
        end
        check_val("timeout_seq_done", seen, 1);
        check_val("timeout_err", err_o, 1);
`else
        seen = 0;
        for (int c = 0; c < 10000; c++) begin
            cyc();
            if (seq_done_o) seen = 1;
        end
        check_val("stall_busy", busy_o, 1);
        check_val("stall_no_done", seen, 0);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
